// File: rtl/seq_detect_sched.sv
`timescale 1ns/1ps
// Purpose: round-robin shared shift/compare engine detecting an overlapping serial pattern on LANES independent bit streams.
// Latency: match_valid/match_lane are registered and appear one cycle after the transfer that completes the pattern.
// Backpressure: at most one lane is granted per cycle, and only in RUN without cfg_wr. Ungranted lanes hold their bit until lane_ready.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   cfg_en                 1 = scheduler runs, 0 = lanes stalled with history kept
//   cfg_wr, cfg_pattern    strobe that loads a new pattern and clears all lane state
//   lane_valid, lane_bit   per-lane serial input with its valid qualifier
//   lane_ready             one-hot grant. A transfer happens when valid & ready.
//   match_valid/lane       one-cycle match pulse and the index of the lane that matched
//   match_total            saturating count of matches (cleared only by rst)
//   busy                   high while lane state is being cleared
module seq_detect_sched #(
    parameter int                 LANES   = 4,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    localparam int                LW      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_en,
    input  logic               cfg_wr,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic [LANES-1:0]   lane_valid,
    input  logic [LANES-1:0]   lane_bit,
    output logic [LANES-1:0]   lane_ready,
    output logic               match_valid,
    output logic [LW-1:0]      match_lane,
    output logic [15:0]        match_total,
    output logic               busy
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PAT_LEN-1:0]   pattern_q, pattern_d;
    logic [PAT_LEN-1:0]   hist_q [LANES];
    logic [PAT_LEN-1:0]   hist_d [LANES];
    logic [FW-1:0]        fill_q [LANES];
    logic [FW-1:0]        fill_d [LANES];
    logic [LW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [LW-1:0]        clr_idx_q, clr_idx_d;
    logic                 match_valid_q, match_valid_d;
    logic [LW-1:0]        match_lane_q, match_lane_d;
    logic [15:0]          match_total_q, match_total_d;

    logic                 gnt_found;
    logic [LW-1:0]        gnt_idx;
    int                   scan;
    logic [PAT_LEN-1:0]   new_hist;
    logic [FW-1:0]        new_fill;

    // Round-robin grant: first valid lane at or after rr_ptr, with wrap.
    // cfg_wr suppresses the grant so a pattern reload never races a transfer.
    always_comb begin
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        lane_ready = '0;
        scan       = 0;
        if (state_q == ST_RUN && !cfg_wr) begin
            for (int k = 0; k < LANES; k++) begin
                scan = (int'(rr_ptr_q) + k) % LANES;
                if (!gnt_found && lane_valid[scan]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = LW'(scan);
                end
            end
            if (gnt_found) begin
                lane_ready[gnt_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        rr_ptr_d      = rr_ptr_q;
        clr_idx_d     = clr_idx_q;
        match_valid_d = 1'b0;
        match_lane_d  = match_lane_q;
        match_total_d = match_total_q;
        new_hist      = '0;
        new_fill      = '0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A transfer completes even when cfg_en drops in the same cycle.
                if (gnt_found) begin
                    new_hist = {hist_q[gnt_idx][PAT_LEN-2:0], lane_bit[gnt_idx]};
                    new_fill = (fill_q[gnt_idx] == FILL_FULL) ? FILL_FULL
                                                              : fill_q[gnt_idx] + 1'b1;
                    hist_d[gnt_idx] = new_hist;
                    fill_d[gnt_idx] = new_fill;
                    rr_ptr_d = (gnt_idx == LAST_LANE) ? '0 : gnt_idx + 1'b1;
                    // The fill count stops a short history padded with reset zeros
                    // from matching a pattern whose leading bits are zero.
                    if (new_hist == pattern_q && new_fill == FILL_FULL) begin
                        match_valid_d = 1'b1;
                        match_lane_d  = gnt_idx;
                        if (match_total_q != 16'hFFFF) begin
                            match_total_d = match_total_q + 16'd1;
                        end
                    end
                end
                if (!cfg_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                hist_d[clr_idx_q] = '0;
                fill_d[clr_idx_q] = '0;
                if (clr_idx_q == LAST_LANE) begin
                    clr_idx_d = '0;
                    state_d   = cfg_en ? ST_RUN : ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A reload overrides every state and restarts the clear sweep from lane 0.
        if (cfg_wr) begin
            state_d   = ST_CLEAR;
            pattern_d = cfg_pattern;
            clr_idx_d = '0;
            hist_d    = hist_q;
            fill_d    = fill_q;
            if (state_q == ST_RUN && gnt_found) begin
                hist_d[gnt_idx] = new_hist;
                fill_d[gnt_idx] = new_fill;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pattern_q     <= PATTERN;
            for (int i = 0; i < LANES; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
            end
            rr_ptr_q      <= '0;
            clr_idx_q     <= '0;
            match_valid_q <= 1'b0;
            match_lane_q  <= '0;
            match_total_q <= '0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            for (int i = 0; i < LANES; i++) begin
                hist_q[i] <= hist_d[i];
                fill_q[i] <= fill_d[i];
            end
            rr_ptr_q      <= rr_ptr_d;
            clr_idx_q     <= clr_idx_d;
            match_valid_q <= match_valid_d;
            match_lane_q  <= match_lane_d;
            match_total_q <= match_total_d;
        end
    end

    assign match_valid = match_valid_q;
    assign match_lane  = match_lane_q;
    assign match_total = match_total_q;
    assign busy        = (state_q == ST_CLEAR);

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
Shared-engine serial pattern detector for several independent bit streams. Round-robin scheduler grants one lane per cycle to a single shift/compare engine that keeps per-lane history, so each lane sees its own overlapping Mealy-style detector (default pattern 1011). Includes a small config/control FSM for enable and runtime pattern reload, with per-lane state clear. Sits between serial front-ends and downstream event logic.

Parameters:
LANES, 4, number of serial input lanes (2..8)
PAT_LEN, 4, pattern length in bits (2..8)
PATTERN, 4'b1011, reset value of pattern register, MSB = oldest bit

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
cfg_en  input  1  1 = scheduler runs; 0 = lanes stalled, history kept
cfg_wr  input  1  single-cycle strobe: load cfg_pattern, clear all lane state
cfg_pattern  input  PAT_LEN  new pattern, sampled when cfg_wr=1
lane_valid  input  LANES  lane i presents a bit
lane_bit  input  LANES  serial data bit of lane i
lane_ready  output  LANES  one-hot grant; transfer when valid&ready
match_valid  output  1  one-cycle pulse: pattern completed on a lane
match_lane  output  clog2(LANES)  lane index of match, valid with match_valid
match_total  output  16  saturating count of all matches
busy  output  1  high while in CLEAR

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values:
  - FSM = IDLE; pattern register = PATTERN.
  - All lane histories = 0, all fill counts = 0, rr_ptr = 0.
  - match_valid = 0, match_lane = 0, match_total = 0, busy = 0.
  - lane_ready = 0.
- Priority: rst > cfg_wr > cfg_en.
- FSM states:
  - IDLE: lane_ready = 0. cfg_wr -> CLEAR. Else cfg_en=1 -> RUN.
  - RUN: grants are issued. cfg_wr -> CLEAR. Else cfg_en=0 -> IDLE. Histories are retained across IDLE.
  - CLEAR: busy = 1, lane_ready = 0.
    - Entry loads the pattern and sets clr_idx = 0.
    - Each cycle clears the history and fill count of lane clr_idx.
    - After LANES cycles, goes to RUN if cfg_en=1, else IDLE.
    - cfg_wr during CLEAR reloads the pattern and restarts at clr_idx = 0.
- Grant (RUN only, combinational):
  - Grant the first lane with lane_valid=1, searching from rr_ptr upward with wrap.
  - lane_ready is one-hot or zero. It is never asserted to a non-valid lane.
  - After a transfer, rr_ptr <= granted+1 mod LANES. With no transfer, rr_ptr is unchanged.
- Engine, on transfer from lane g:
  - hist[g] <= {hist[g][PAT_LEN-2:0], lane_bit[g]}.
  - fill[g] <= min(fill[g]+1, PAT_LEN).
  - A match occurs when the new history equals the pattern and new fill = PAT_LEN.
  - Overlap is allowed. Example: 1011011 gives two matches.
- Match output:
  - Registered: match_valid = 1 and match_lane = g in the cycle after the transfer.
  - match_valid is 0 in all other cycles.
  - match_lane holds its last value when match_valid = 0.
  - match_total increments on each match and saturates at 16'hFFFF. It is cleared only by rst, not by CLEAR.
- Simultaneous events:
  - cfg_en falling in a RUN cycle with a transfer: the transfer completes and its match is still reported. Next state is IDLE.
  - cfg_wr in a RUN cycle: no grant that cycle; lane_ready is forced to 0 when cfg_wr=1.
  - A match from the prior cycle still pulses on the cycle after a cfg_wr.
- Mid-operation reset: rst wins over everything. The next cycle has all reset values; a pending match pulse is dropped.
- Lane isolation: a lane's history is touched only by its own transfers or by CLEAR.

Test Plan:
- Reset, cfg_en=1, lane0 only streams 1,0,1,1 -> lane_ready[0]=1 each cycle; match_valid=1, match_lane=0 one cycle after 4th bit; match_total=1.
- Lane0 streams 1011011 -> exactly two match pulses, at bits 4 and 7; no pulse at bits 5, 6.
- All 4 lanes valid, streaming 1011 each -> grants rotate 0,1,2,3,0,...; each lane matches once in cycles 13-16; match_lane sequence 0,1,2,3.
- Lanes 1,3 interleaved: lane1=1,0, lane3=1,1, lane1=1,1 -> lane1 match only; lane3 history unaffected.
- cfg_wr with cfg_pattern=4'b0110 mid-stream -> busy high 4 cycles, lane_ready=0 throughout; then 0110 on lane2 matches and old partial 10 history does not combine.
- cfg_en=0 after lane0 sends 101, hold 5 cycles, re-enable, send 1 -> match; rst mid-stream -> match_total=0, next 1 alone gives no match.
